// File: rtl/sram_if.sv
// SRAM-style data port bundle between the CPU data-memory stage and its memory.
// The master drives the request; the slave returns rdata, stall and err.
interface sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  modport master (
    output en, wen, addr, wdata,
    input  rdata, stall, err
  );

  modport slave (
    input  en, wen, addr, wdata,
    output rdata, stall, err
  );
endinterface

// File: rtl/sram_mem_responder.sv
// Word-organised data memory with registered read data and optional wait states.
// Out-of-range rejection with err pulse is enabled by `SRAM_RESP_ERR_EN.
module sram_mem_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input logic   clk,
  input logic   resetn,
  sram_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state;
  state_t state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  req_t req;
  req_t cur;
  req_t acc;
  logic latch;
  logic go;
  logic stall;
  logic ok;
  logic [ADDR_W-1:0] idx;
  logic [31:0] rdata_q;
  logic err_q;
  logic [31:0] ram [DEPTH];

  assign cur = '{wen: bus.wen, addr: bus.addr, wdata: bus.wdata};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    latch    = 1'b0;
    go       = 1'b0;
    stall    = 1'b0;
    if (WAIT_CYCLES == 0) begin
      go = bus.en;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.en) begin
            latch    = 1'b1;
            stall    = 1'b1;
            cnt_nx   = CNT_INIT;
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            stall  = 1'b1;
            cnt_nx = cnt - 4'd1;
          end else begin
            go       = 1'b1;
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
    if (!resetn) begin
      stall = 1'b0;
      go    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      req   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch) req <= cur;
    end
  end

  // With no wait states the live request is the access itself.
  assign acc = (WAIT_CYCLES == 0) ? cur : req;
  assign idx = acc.addr[ADDR_W+1:2];

`ifdef SRAM_RESP_ERR_EN
  assign ok = (acc.addr >> (ADDR_W + 2)) == 32'd0;
`else
  assign ok = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{acc.addr[1:0], acc.addr[31:ADDR_W+2]};

  always_ff @(posedge clk) begin
    if (go && ok) begin
      for (int i = 0; i < 4; i++) begin
        if (acc.wen[i]) ram[idx][8*i +: 8] <= acc.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= go && !ok;
      if (go && acc.wen == 4'd0) begin
        rdata_q <= ok ? ram[idx] : ERR_DATA;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.stall = stall;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed plus randomized checks of sram_mem_responder against a word-array model.
// Two instances: zero wait states and three wait states.
module tb_sram_mem_responder;

  localparam int AW = 14;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk;
  logic rst0;
  logic rst1;
  sram_if b0 ();
  sram_if b1 ();

  sram_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0), .ERR_DATA(ERR)) u0 (
    .clk(clk), .resetn(rst0), .bus(b0)
  );

  sram_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(3), .ERR_DATA(ERR)) u1 (
    .clk(clk), .resetn(rst1), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem0 [int];
  logic [31:0] mem1 [int];
  logic [31:0] exp_rd0 = 32'd0;
  logic [31:0] exp_rd1 = 32'd0;
  logic exp_err0 = 1'b0;
  logic exp_err1 = 1'b0;
  logic [13:0] pool [16];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
`ifdef SRAM_RESP_ERR_EN
    return (a >> (AW + 2)) == 32'd0;
`else
    return a[31] | 1'b1;
`endif
  endfunction

  // Reference: memory of words, byte-lane merge, rdata only moves on reads.
  task automatic model(input int d, input logic [3:0] wen,
                       input logic [31:0] a, input logic [31:0] wd);
    int idx = int'(a[AW+1:2]);
    bit ok = in_range(a);
    logic [31:0] w;
    if (d == 0) exp_err0 = !ok; else exp_err1 = !ok;
    if (wen == 4'd0) begin
      if (!ok) w = ERR;
      else if (d == 0) w = mem0[idx];
      else w = mem1[idx];
      if (d == 0) exp_rd0 = w; else exp_rd1 = w;
    end else if (ok) begin
      w = (d == 0) ? (mem0.exists(idx) ? mem0[idx] : 32'd0)
                   : (mem1.exists(idx) ? mem1[idx] : 32'd0);
      for (int i = 0; i < 4; i++)
        if (wen[i]) w[8*i +: 8] = wd[8*i +: 8];
      if (d == 0) mem0[idx] = w; else mem1[idx] = w;
    end
  endtask

  task automatic acc0(input logic [3:0] wen, input logic [31:0] a,
                      input logic [31:0] wd);
    b0.en = 1'b1;
    b0.wen = wen;
    b0.addr = a;
    b0.wdata = wd;
    #1 chk("stall0", 32'(b0.stall), 32'd0);
    model(0, wen, a, wd);
    @(negedge clk);
    chk("rdata0", b0.rdata, exp_rd0);
    chk("err0", 32'(b0.err), 32'(exp_err0));
  endtask

  task automatic idle0();
    b0.en = 1'b0;
    b0.wen = 4'd0;
    @(negedge clk);
    exp_err0 = 1'b0;
    chk("idle_rdata0", b0.rdata, exp_rd0);
    chk("idle_err0", 32'(b0.err), 32'd0);
  endtask

  task automatic scramble1();
    b1.en = 1'($urandom_range(0, 1));
    b1.wen = 4'($urandom_range(0, 15));
    b1.addr = $urandom;
    b1.wdata = $urandom;
  endtask

  task automatic acc3(input logic [3:0] wen, input logic [31:0] a,
                      input logic [31:0] wd);
    b1.en = 1'b1;
    b1.wen = wen;
    b1.addr = a;
    b1.wdata = wd;
    #1 chk("stall1_t0", 32'(b1.stall), 32'd1);
    model(1, wen, a, wd);
    @(negedge clk);
    scramble1();
    #1 chk("stall1_t1", 32'(b1.stall), 32'd1);
    @(negedge clk);
    scramble1();
    #1 chk("stall1_t2", 32'(b1.stall), 32'd1);
    @(negedge clk);
    b1.en = 1'b0;
    #1 chk("stall1_t3", 32'(b1.stall), 32'd0);
    @(negedge clk);
    chk("rdata1", b1.rdata, exp_rd1);
    chk("err1", 32'(b1.err), 32'(exp_err1));
  endtask

  initial begin
    logic [3:0] wen;
    logic [31:0] a;
    logic [15:0] up;
    rst0 = 1'b0;
    rst1 = 1'b0;
    b0.en = 1'b0; b0.wen = 4'd0; b0.addr = 32'd0; b0.wdata = 32'd0;
    b1.en = 1'b0; b1.wen = 4'd0; b1.addr = 32'd0; b1.wdata = 32'd0;
    repeat (3) @(negedge clk);
    b0.en = 1'b1;
    b1.en = 1'b1;
    #1 chk("rst_stall0", 32'(b0.stall), 32'd0);
    chk("rst_stall1", 32'(b1.stall), 32'd0);
    b0.en = 1'b0;
    b1.en = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    rst1 = 1'b1;
    chk("rst_rdata0", b0.rdata, 32'd0);
    chk("rst_rdata1", b1.rdata, 32'd0);
    chk("rst_err0", 32'(b0.err), 32'd0);
    chk("rst_err1", 32'(b1.err), 32'd0);

    acc0(4'hF, 32'h10, 32'h1122_3344);
    acc0(4'h0, 32'h10, 32'h0);
    chk("t1_rd", b0.rdata, 32'h1122_3344);
    idle0();

    acc0(4'hF, 32'h20, 32'hAABB_CCDD);
    acc0(4'b0010, 32'h20, 32'h0000_EE00);
    acc0(4'h0, 32'h20, 32'h0);
    chk("t2_lane", b0.rdata, 32'hAABB_EEDD);
    acc0(4'h0, 32'h22, 32'h0);
    chk("t2_off", b0.rdata, 32'hAABB_EEDD);
    idle0();

    acc0(4'hF, 32'h0, 32'h0BAD_F00D);
    acc0(4'hF, 32'h0001_0000, 32'h5566_7788);
    acc0(4'h0, 32'h0, 32'h0);
`ifdef SRAM_RESP_ERR_EN
    chk("t5_word0", b0.rdata, 32'h0BAD_F00D);
`else
    chk("t5_alias", b0.rdata, 32'h5566_7788);
`endif
    acc0(4'h0, 32'h0001_0000, 32'h0);
    idle0();

    acc0(4'hF, 32'h100, 32'hA5A5_0001);
    acc0(4'h0, 32'h100, 32'h0);
    chk("t6_rA", b0.rdata, 32'hA5A5_0001);
    acc0(4'hF, 32'h104, 32'h5A5A_0002);
    acc0(4'h0, 32'h104, 32'h0);
    chk("t6_rB", b0.rdata, 32'h5A5A_0002);
    idle0();

    for (int k = 0; k < 16; k++) begin
      pool[k] = 14'($urandom_range(0, 16383));
      acc0(4'hF, {16'd0, pool[k], 2'b00}, $urandom);
    end
    for (int n = 0; n < 80; n++) begin
      up = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
      wen = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      a = {up, pool[$urandom_range(0, 15)], 2'($urandom_range(0, 3))};
      acc0(wen, a, $urandom);
      if (n % 10 == 9) idle0();
    end
    idle0();

    acc3(4'hF, 32'h40, 32'h1234_5678);
    b1.en = 1'b1;
    b1.wen = 4'hF;
    b1.addr = 32'h40;
    b1.wdata = 32'hCAFE_F00D;
    #1 chk("t4_stall", 32'(b1.stall), 32'd1);
    @(negedge clk);
    rst1 = 1'b0;
    b1.en = 1'b0;
    #1 chk("t4_rst_stall", 32'(b1.stall), 32'd0);
    @(negedge clk);
    rst1 = 1'b1;
    exp_rd1 = 32'd0;
    exp_err1 = 1'b0;
    chk("t4_rdata", b1.rdata, 32'd0);
    chk("t4_stall_after", 32'(b1.stall), 32'd0);
    acc3(4'h0, 32'h40, 32'h0);
    chk("t4_kept", b1.rdata, 32'h1234_5678);

    for (int n = 0; n < 8; n++) begin
      a = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      acc3(4'hF, a, $urandom);
      acc3(4'($urandom_range(0, 15)), a | 32'($urandom_range(0, 3)), $urandom);
      acc3(4'h0, a, 32'h0);
    end
    acc3(4'hF, 32'h0002_0000, 32'h7777_7777);
    acc3(4'h0, 32'h0002_0000, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
